// File: rtl/awmc_pkg.sv
// Shared stage/mode codes and duration scaling for the programmable washer controller.
package awmc_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FILL  = 3'd1;
    localparam logic [2:0] WASH  = 3'd2;
    localparam logic [2:0] RINSE = 3'd3;
    localparam logic [2:0] SPIN  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
    localparam logic [2:0] FAULT = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = IDLE,
        S_FILL  = FILL,
        S_WASH  = WASH,
        S_RINSE = RINSE,
        S_SPIN  = SPIN,
        S_DONE  = DONE,
        S_FAULT = FAULT
    } state_e;

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_QUICK  = 2'd1;
    localparam logic [1:0] MODE_HEAVY  = 2'd2;
    localparam logic [1:0] MODE_RINSE  = 2'd3;

    // Programme-dependent stage length: quick halves (min 1), heavy doubles WASH (saturating).
    function automatic int unsigned stage_dur(input int unsigned base, input logic [1:0] mode,
                                              input logic is_wash, input int unsigned max_val);
        int unsigned d;
        d = base;
        case (mode)
            MODE_QUICK: d = ((base >> 1) == 32'd0) ? 32'd1 : (base >> 1);
            MODE_HEAVY: if (is_wash) d = ((2 * base) > max_val) ? max_val : (2 * base);
            default:    d = base;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/awmc_if.sv
// Front-panel inputs and driver-side status outputs of the washer controller.
interface awmc_if #(parameter int unsigned CNT_W = 8);
    logic             start;
    logic             pause;
    logic             lid;
    logic [1:0]       mode;
    logic [2:0]       stage;
    logic             done;
    logic             paused;
    logic             lid_lock;
    logic             fault;
    logic [1:0]       rinse_idx;
    logic [CNT_W-1:0] remaining;

    modport master (output start, pause, lid, mode,
                    input  stage, done, paused, lid_lock, fault, rinse_idx, remaining);
    modport slave  (input  start, pause, lid, mode,
                    output stage, done, paused, lid_lock, fault, rinse_idx, remaining);
endinterface

// File: rtl/awmc_timer.sv
// Loadable stage down-counter; stops at zero, load wins over hold.
module awmc_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             hold,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             zero_c
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (!hold && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/awmc_prog.sv
// Programmable washer sequencer: FILL/WASH/RINSE/SPIN with pause, lid hold, spin lock and fault.
module awmc_prog import awmc_pkg::*; #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned FILL_T  = 4,
    parameter int unsigned WASH_T  = 8,
    parameter int unsigned RINSE_T = 4,
    parameter int unsigned SPIN_T  = 6,
    parameter int unsigned RINSE_N = 1
) (
    input  logic  clk,
    input  logic  reset,
    awmc_if.slave bus
);

    localparam int unsigned CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
    localparam int unsigned HEAVY_N = ((RINSE_N + 1) > 4) ? 4 : (RINSE_N + 1);

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       rinse_q, rinse_d;
    logic             paused_q, paused_d;
    logic             tmr_load, tmr_hold, tmr_zero_c;
    logic [CNT_W-1:0] tmr_val, tmr_cnt;
    logic             go_c, frozen_c;
    logic [1:0]       last_idx_c;

    function automatic logic [CNT_W-1:0] reload(input int unsigned base, input logic [1:0] m,
                                                input logic is_wash);
        return CNT_W'(stage_dur(base, m, is_wash, CNT_MAX) - 32'd1);
    endfunction

    awmc_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (reset),
        .load     (tmr_load),
        .hold     (tmr_hold),
        .load_val (tmr_val),
        .cnt      (tmr_cnt),
        .zero_c   (tmr_zero_c)
    );

    assign go_c       = bus.start & bus.lid & ~bus.pause;
    assign frozen_c   = bus.pause | ~bus.lid;
    assign last_idx_c = (mode_q == MODE_HEAVY) ? 2'(HEAVY_N - 1) : 2'(RINSE_N - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            mode_q   <= MODE_NORMAL;
            rinse_q  <= 2'd0;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            rinse_q  <= rinse_d;
            paused_q <= paused_d;
        end
    end

    // Next stage, timer control and freeze flag; a frozen edge keeps the timer where it is.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        rinse_d  = rinse_q;
        paused_d = 1'b0;
        tmr_load = 1'b0;
        tmr_hold = 1'b1;
        tmr_val  = '0;
        case (state_q)
            S_IDLE: begin
                if (go_c) begin
                    state_d  = S_FILL;
                    mode_d   = bus.mode;
                    rinse_d  = 2'd0;
                    tmr_load = 1'b1;
                    tmr_val  = reload(FILL_T, bus.mode, 1'b0);
                end
            end
            S_FILL, S_WASH, S_RINSE: begin
                if (frozen_c) begin
                    paused_d = 1'b1;
                end else if (!tmr_zero_c) begin
                    tmr_hold = 1'b0;
                end else begin
                    tmr_load = 1'b1;
                    if (state_q == S_FILL && mode_q != MODE_RINSE) begin
                        state_d = S_WASH;
                        tmr_val = reload(WASH_T, mode_q, 1'b1);
                    end else if (state_q != S_RINSE) begin
                        state_d = S_RINSE;
                        tmr_val = reload(RINSE_T, mode_q, 1'b0);
                    end else if (rinse_q != last_idx_c) begin
                        rinse_d = rinse_q + 2'd1;
                        tmr_val = reload(RINSE_T, mode_q, 1'b0);
                    end else begin
                        state_d = S_SPIN;
                        tmr_val = reload(SPIN_T, mode_q, 1'b0);
                    end
                end
            end
            S_SPIN: begin
                if (!bus.lid) begin
                    state_d  = S_FAULT;
                    tmr_load = 1'b1;
                end else if (bus.pause) begin
                    paused_d = 1'b1;
                end else if (tmr_zero_c) begin
                    state_d = S_DONE;
                end else begin
                    tmr_hold = 1'b0;
                end
            end
            S_DONE: begin
                if (!bus.lid) state_d = S_IDLE;
            end
            S_FAULT: begin
                if (go_c) begin
                    state_d  = S_SPIN;
                    tmr_load = 1'b1;
                    tmr_val  = reload(SPIN_T, mode_q, 1'b0);
                end
            end
            default: begin
                state_d  = S_IDLE;
                tmr_load = 1'b1;
            end
        endcase
    end

    assign bus.stage     = state_q;
    assign bus.done      = (state_q == S_DONE);
    assign bus.lid_lock  = (state_q == S_SPIN);
    assign bus.fault     = (state_q == S_FAULT);
    assign bus.paused    = paused_q;
    assign bus.rinse_idx = rinse_q;
    assign bus.remaining = tmr_cnt;

endmodule

// File: tb/tb_awmc_prog.sv
// Directed bench for awmc_prog at default parameters with hand-computed stage timings.
module tb_awmc_prog;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   hist[8];
    int   max_ri;

    always #5 clk = ~clk;

    awmc_if #(.CNT_W(8)) bus ();

    awmc_prog #(
        .CNT_W(8), .FILL_T(4), .WASH_T(8), .RINSE_T(4), .SPIN_T(6), .RINSE_N(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        hist[bus.stage]++;
        if (int'(bus.rinse_idx) > max_ri) max_ri = int'(bus.rinse_idx);
    endtask

    // Acceptance edge is cycle 0 of the run; its sample counts as the first FILL cycle.
    task automatic accept(input logic [1:0] m);
        bus.mode  = m;
        bus.lid   = 1'b1;
        bus.pause = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        foreach (hist[i]) hist[i] = 0;
        max_ri = 0;
        sample();
    endtask

    task automatic finish_run(input int n0, output int n);
        n = n0;
        while (bus.done !== 1'b1 && n < 400) begin
            step();
            n++;
            if (bus.done !== 1'b1) sample();
        end
    endtask

    task automatic open_door();
        bus.lid = 1'b0;
        step();
        bus.lid = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b0; bus.pause = 1'b0; bus.lid = 1'b1; bus.mode = 2'd0;
        #2;
        checks++;
        if ({bus.stage, bus.done, bus.paused, bus.lid_lock, bus.fault, bus.rinse_idx, bus.remaining} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: stage=%0d done=%0d rem=%0d want all 0", bus.stage, bus.done, bus.remaining);
        end
        step(); step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_normal();
        int n;
        accept(2'd0);
        checks++;
        if (bus.stage !== 3'd1 || bus.remaining !== 8'd3) begin
            errors++;
            $display("FAIL normal_fill_entry: stage=%0d rem=%0d want 1/3", bus.stage, bus.remaining);
        end
        finish_run(0, n);
        checks++;
        if (n != 22) begin errors++; $display("FAIL normal_done_cycle: got %0d want 22", n); end
        checks++;
        if (hist[1] != 4 || hist[2] != 8 || hist[3] != 4 || hist[4] != 6) begin
            errors++;
            $display("FAIL normal_stage_lengths: got %0d/%0d/%0d/%0d want 4/8/4/6", hist[1], hist[2], hist[3], hist[4]);
        end
        checks++;
        if (bus.stage !== 3'd5 || bus.remaining !== 8'd0 || bus.lid_lock !== 1'b0) begin
            errors++;
            $display("FAIL normal_done_state: stage=%0d rem=%0d lock=%0d want 5/0/0", bus.stage, bus.remaining, bus.lid_lock);
        end
        bus.start = 1'b1;
        step(); step();
        bus.start = 1'b0;
        checks++;
        if (bus.stage !== 3'd5) begin errors++; $display("FAIL done_no_retrigger: stage=%0d want 5", bus.stage); end
        open_door();
        checks++;
        if (bus.stage !== 3'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL done_to_idle: stage=%0d done=%0d want 0/0", bus.stage, bus.done);
        end
    endtask

    task automatic test_quick();
        int n;
        accept(2'd1);
        finish_run(0, n);
        checks++;
        if (n != 11) begin errors++; $display("FAIL quick_done_cycle: got %0d want 11", n); end
        checks++;
        if (hist[1] != 2 || hist[2] != 4 || hist[3] != 2 || hist[4] != 3) begin
            errors++;
            $display("FAIL quick_stage_lengths: got %0d/%0d/%0d/%0d want 2/4/2/3", hist[1], hist[2], hist[3], hist[4]);
        end
        open_door();
    endtask

    task automatic test_heavy();
        int n;
        accept(2'd2);
        finish_run(0, n);
        checks++;
        if (n != 34) begin errors++; $display("FAIL heavy_done_cycle: got %0d want 34", n); end
        checks++;
        if (hist[2] != 16 || hist[3] != 8 || max_ri != 1) begin
            errors++;
            $display("FAIL heavy_wash_rinse: wash=%0d rinse=%0d max_idx=%0d want 16/8/1", hist[2], hist[3], max_ri);
        end
        open_door();
    endtask

    task automatic test_rinse_only();
        int n;
        accept(2'd3);
        checks++;
        if (bus.rinse_idx !== 2'd0) begin errors++; $display("FAIL rinse_idx_clear: got %0d want 0", bus.rinse_idx); end
        finish_run(0, n);
        checks++;
        if (n != 14) begin errors++; $display("FAIL rinse_only_done_cycle: got %0d want 14", n); end
        checks++;
        if (hist[2] != 0 || hist[3] != 4) begin
            errors++;
            $display("FAIL rinse_only_stages: wash=%0d rinse=%0d want 0/4", hist[2], hist[3]);
        end
        open_door();
    endtask

    task automatic test_freeze();
        int n;
        accept(2'd0);
        n = 0;
        repeat (6) begin step(); n++; end
        checks++;
        if (bus.stage !== 3'd2 || bus.remaining !== 8'd5) begin
            errors++;
            $display("FAIL freeze_wash_pos: stage=%0d rem=%0d want 2/5", bus.stage, bus.remaining);
        end
        bus.pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(); n++;
            checks++;
            if (bus.paused !== 1'b1 || bus.remaining !== 8'd5) begin
                errors++;
                $display("FAIL pause_hold[%0d]: paused=%0d rem=%0d want 1/5", i, bus.paused, bus.remaining);
            end
        end
        bus.pause = 1'b0;
        step(); n++;
        checks++;
        if (bus.paused !== 1'b0 || bus.remaining !== 8'd4) begin
            errors++;
            $display("FAIL pause_resume: paused=%0d rem=%0d want 0/4", bus.paused, bus.remaining);
        end
        while (bus.stage !== 3'd3 && n < 200) begin step(); n++; end
        step(); n++;
        checks++;
        if (n != 18 || bus.remaining !== 8'd2) begin
            errors++;
            $display("FAIL freeze_rinse_pos: n=%0d rem=%0d want 18/2", n, bus.remaining);
        end
        bus.lid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); n++;
            checks++;
            if (bus.paused !== 1'b1 || bus.remaining !== 8'd2 || bus.stage !== 3'd3) begin
                errors++;
                $display("FAIL lid_hold[%0d]: paused=%0d rem=%0d stage=%0d want 1/2/3", i, bus.paused, bus.remaining, bus.stage);
            end
        end
        bus.lid = 1'b1;
        finish_run(n, n);
        checks++;
        if (n != 30) begin errors++; $display("FAIL freeze_done_cycle: got %0d want 30", n); end
        open_door();
    endtask

    task automatic test_spin_fault();
        int n;
        accept(2'd0);
        n = 0;
        while (!(bus.stage === 3'd4 && bus.remaining === 8'd3) && n < 100) begin step(); n++; end
        checks++;
        if (n != 18) begin errors++; $display("FAIL spin_rem3_cycle: got %0d want 18", n); end
        bus.lid = 1'b0;
        step();
        checks++;
        if (bus.stage !== 3'd6 || bus.fault !== 1'b1 || bus.lid_lock !== 1'b0 || bus.remaining !== 8'd0) begin
            errors++;
            $display("FAIL spin_fault: stage=%0d fault=%0d lock=%0d rem=%0d want 6/1/0/0", bus.stage, bus.fault, bus.lid_lock, bus.remaining);
        end
        bus.lid = 1'b1;
        step(); step();
        checks++;
        if (bus.stage !== 3'd6) begin errors++; $display("FAIL fault_sticky: stage=%0d want 6", bus.stage); end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.stage !== 3'd4 || bus.remaining !== 8'd5 || bus.lid_lock !== 1'b1 || bus.fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_recover: stage=%0d rem=%0d lock=%0d fault=%0d want 4/5/1/0", bus.stage, bus.remaining, bus.lid_lock, bus.fault);
        end
        finish_run(0, n);
        checks++;
        if (n != 6) begin errors++; $display("FAIL fault_spin_len: got %0d want 6", n); end
        open_door();
    endtask

    task automatic test_ignore_and_latch();
        int n;
        bus.lid = 1'b0;
        bus.start = 1'b1;
        step(); step();
        bus.start = 1'b0;
        checks++;
        if (bus.stage !== 3'd0) begin errors++; $display("FAIL start_lid_open: stage=%0d want 0", bus.stage); end
        bus.lid = 1'b1;
        step();
        accept(2'd1);
        bus.mode = 2'd2;
        finish_run(0, n);
        checks++;
        if (n != 11) begin errors++; $display("FAIL mode_latched: got %0d want 11", n); end
        open_door();
    endtask

    task automatic test_async_reset();
        accept(2'd0);
        repeat (6) step();
        checks++;
        if (bus.stage !== 3'd2) begin errors++; $display("FAIL reset_pre_wash: stage=%0d want 2", bus.stage); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus.stage, bus.done, bus.paused, bus.lid_lock, bus.fault, bus.rinse_idx, bus.remaining} !== 17'd0) begin
            errors++;
            $display("FAIL async_reset: stage=%0d rem=%0d want 0/0", bus.stage, bus.remaining);
        end
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_quick();
        test_heavy();
        test_rinse_only();
        test_freeze();
        test_spin_fault();
        test_ignore_and_latch();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
